// File: rtl/scratch_arbiter.sv
// Scratch RAM port arbiter: fixed stack priority, starvation-bounded execute access,
// and a lock that keeps multi-cycle stack sequences atomic.
module scratch_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 10,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stk_req,
    input  logic              stk_we,
    input  logic              stk_lock,
    input  logic [ADDR_W-1:0] stk_addr,
    input  logic [DATA_W-1:0] stk_wdata,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stk_gnt,
    output logic              ex_gnt,
    output logic              stk_stall,
    output logic              ex_stall,
    output logic              stk_rvalid,
    output logic              ex_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              dbg_state,
    output logic [3:0]        dbg_starve_cnt
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;

    // Priority: reset, lock ownership, starved ex, stack, ex.
    always_comb begin
        stk_gnt = 1'b0;
        ex_gnt  = 1'b0;
        if (!reset) begin
            if (state == LOCKED) begin
                stk_gnt = stk_req;
            end else if (ex_req && (starve_cnt == MAX_CNT)) begin
                ex_gnt = 1'b1;
            end else if (stk_req) begin
                stk_gnt = 1'b1;
            end else if (ex_req) begin
                ex_gnt = 1'b1;
            end
        end
    end

    assign stk_stall = stk_req && !stk_gnt;
    assign ex_stall  = ex_req && !ex_gnt;
    assign rdata     = ram_rdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (stk_gnt) begin
            ram_we    = stk_we;
            ram_addr  = stk_addr;
            ram_wdata = stk_wdata;
        end else if (ex_gnt) begin
            ram_we    = ex_we;
            ram_addr  = ex_addr;
            ram_wdata = ex_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stk_gnt && stk_lock) state_nxt = LOCKED;
            LOCKED:  if (!stk_lock) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counting carries on through a lock so ex wins right after it releases.
    always_comb begin
        starve_nxt = starve_cnt;
        if (ex_gnt || !ex_req) begin
            starve_nxt = 4'd0;
        end else if (starve_cnt < MAX_CNT) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            stk_rvalid <= 1'b0;
            ex_rvalid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            stk_rvalid <= stk_gnt && !stk_we;
            ex_rvalid  <= ex_gnt && !ex_we;
        end
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_scratch_arbiter.sv
// Directed bench for scratch_arbiter: a cycle-by-cycle vector table plus a
// hand-written lock/starvation saturation sequence, against a small RAM model.
module tb_scratch_arbiter;

    logic       clk;
    logic       reset;
    logic       stk_req, stk_we, stk_lock;
    logic [7:0] stk_addr;
    logic [9:0] stk_wdata;
    logic       ex_req, ex_we;
    logic [7:0] ex_addr;
    logic [9:0] ex_wdata;
    logic [9:0] ram_rdata;
    logic       stk_gnt, ex_gnt, stk_stall, ex_stall, stk_rvalid, ex_rvalid;
    logic [9:0] rdata;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [9:0] ram_wdata;
    logic       dbg_state;
    logic [3:0] dbg_starve_cnt;

    int errors = 0;
    int checks = 0;

    scratch_arbiter #(.ADDR_W(8), .DATA_W(10), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .stk_req(stk_req), .stk_we(stk_we), .stk_lock(stk_lock),
        .stk_addr(stk_addr), .stk_wdata(stk_wdata),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ram_rdata(ram_rdata),
        .stk_gnt(stk_gnt), .ex_gnt(ex_gnt), .stk_stall(stk_stall), .ex_stall(ex_stall),
        .stk_rvalid(stk_rvalid), .ex_rvalid(ex_rvalid), .rdata(rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock and reset-free RAM model: write and registered read at the edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // flags = {stk_gnt, ex_gnt, stk_stall, ex_stall, stk_rvalid, ex_rvalid, ram_we}
    typedef struct {
        logic       rst;
        logic       sr, swe, slk;
        logic [7:0] sa;
        logic [9:0] sd;
        logic       er, ewe;
        logic [7:0] ea;
        logic [9:0] ed;
        logic [6:0] flags;
        logic [7:0] addr;
        logic [9:0] wd;
        logic       st;
        logic [3:0] cnt;
        logic       chk_rd;
        logic [9:0] rd;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst;
        stk_req   = v.sr;
        stk_we    = v.swe;
        stk_lock  = v.slk;
        stk_addr  = v.sa;
        stk_wdata = v.sd;
        ex_req    = v.er;
        ex_we     = v.ewe;
        ex_addr   = v.ea;
        ex_wdata  = v.ed;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stk_req = 1'b0; stk_we = 1'b0; stk_lock = 1'b0;
        stk_addr = 8'h00; stk_wdata = 10'h000;
        ex_req = 1'b0; ex_we = 1'b0; ex_addr = 8'h00; ex_wdata = 10'h000;
    endtask

    logic [6:0] act_flags;
    assign act_flags = {stk_gnt, ex_gnt, stk_stall, ex_stall, stk_rvalid, ex_rvalid, ram_we};

    initial begin
        logic got;
        int   wait_cycles;

        //            rst   sr    swe   slk   sa     sd       er    ewe   ea     ed         flags        addr   wd       st    cnt   chk   rd
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 8'h00, 10'h000, 7'b0011000, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000000, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000000, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b1, 8'h10, 10'h2A5, 7'b0100001, 8'h10, 10'h2A5, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 8'h10, 10'h123, 7'b0100000, 8'h10, 10'h123, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000010, 8'h00, 10'h000, 1'b0, 4'd0, 1'b1, 10'h2A5};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 10'h3FF, 1'b0, 1'b0, 8'h00, 10'h000, 7'b1000001, 8'hFF, 10'h3FF, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b1000000, 8'hFF, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000100, 8'h00, 10'h000, 1'b0, 4'd0, 1'b1, 10'h3FF};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 10'h001, 1'b1, 1'b1, 8'h30, 10'h002, 7'b1001001, 8'h20, 10'h001, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 10'h001, 1'b1, 1'b1, 8'h30, 10'h002, 7'b1001001, 8'h20, 10'h001, 1'b0, 4'd1, 1'b0, 10'h000};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 10'h001, 1'b1, 1'b1, 8'h30, 10'h002, 7'b1001001, 8'h20, 10'h001, 1'b0, 4'd2, 1'b0, 10'h000};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 10'h001, 1'b1, 1'b1, 8'h30, 10'h002, 7'b0110001, 8'h30, 10'h002, 1'b0, 4'd3, 1'b0, 10'h000};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 10'h001, 1'b1, 1'b1, 8'h30, 10'h002, 7'b1001001, 8'h20, 10'h001, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000000, 8'h00, 10'h000, 1'b0, 4'd1, 1'b0, 10'h000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000000, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h50, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b1001000, 8'h50, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b0001100, 8'h00, 10'h000, 1'b1, 4'd1, 1'b0, 10'h000};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h51, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b1001000, 8'h51, 10'h000, 1'b1, 4'd2, 1'b0, 10'h000};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b0001100, 8'h00, 10'h000, 1'b1, 4'd3, 1'b0, 10'h000};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h52, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b0110000, 8'h40, 10'h000, 1'b0, 4'd3, 1'b0, 10'h000};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000010, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h60, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b1001000, 8'h60, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h61, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b1001100, 8'h61, 10'h000, 1'b1, 4'd1, 1'b0, 10'h000};
        vecs[24] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h61, 10'h000, 1'b1, 1'b0, 8'h40, 10'h000, 7'b0011100, 8'h00, 10'h000, 1'b1, 4'd2, 1'b0, 10'h000};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 7'b0000000, 8'h00, 10'h000, 1'b0, 4'd0, 1'b0, 10'h000};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b1, 8'h11, 10'h155, 7'b0100001, 8'h11, 10'h155, 1'b0, 4'd0, 1'b0, 10'h000};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check("flags", i, 32'(act_flags), 32'(vecs[i].flags));
            check("ram_addr", i, 32'(ram_addr), 32'(vecs[i].addr));
            check("ram_wdata", i, 32'(ram_wdata), 32'(vecs[i].wd));
            check("state", i, 32'(dbg_state), 32'(vecs[i].st));
            check("starve_cnt", i, 32'(dbg_starve_cnt), 32'(vecs[i].cnt));
            if (vecs[i].chk_rd) check("rdata", i, 32'(rdata), 32'(vecs[i].rd));
            @(posedge clk);
        end

        // Long lock with ex held: count saturates at MAX_WAIT, ex never granted.
        #1;
        idle_inputs();
        stk_req = 1'b1; stk_lock = 1'b1; stk_we = 1'b1; ex_req = 1'b1; ex_we = 1'b1;
        @(negedge clk);
        check("lock_take_gnt", 100, 32'(stk_gnt), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            stk_req = 1'b0;
            @(negedge clk);
            check("lock_ex_gnt", 101 + k, 32'(ex_gnt), 32'd0);
            check("lock_state", 101 + k, 32'(dbg_state), 32'd1);
            check("lock_cnt", 101 + k, 32'(dbg_starve_cnt), (k >= 2) ? 32'd3 : 32'(k + 1));
        end
        @(posedge clk); #1;
        stk_lock = 1'b0;
        @(negedge clk);
        check("unlock_cycle_ex_gnt", 110, 32'(ex_gnt), 32'd0);
        check("unlock_cycle_state", 110, 32'(dbg_state), 32'd1);
        @(posedge clk); #1;
        stk_req = 1'b1;
        got = 1'b0;
        wait_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ex_gnt) begin
                got = 1'b1;
                break;
            end
            wait_cycles++;
            @(posedge clk); #1;
        end
        check("forced_ex_seen", 111, 32'(got), 32'd1);
        check("forced_ex_latency", 111, 32'(wait_cycles), 32'd0);
        check("forced_ex_stk_stall", 111, 32'(stk_stall), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("after_force_cnt", 112, 32'(dbg_starve_cnt), 32'd0);
        check("after_force_state", 112, 32'(dbg_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
